// File: rtl/vram_pkg.sv
// Shared types and address helpers for the banked video RAM.
// The fill engine state enum and the bank/offset split live here so every file agrees on them.
package vram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    // Callers zero-extend the address to 32 bits and truncate the results to their own widths.
    function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int unsigned bank_aw);
        return addr >> bank_aw;
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int unsigned bank_aw);
        return addr & ((32'd1 << bank_aw) - 32'd1);
    endfunction

endpackage

// File: rtl/vram_bank_dp.sv
// One RAM bank with two ports: port 1 is read/write, port 2 is read-only.
// Both read ports are registered and read-first. Port 1 only updates its output register on a read.
module vram_bank_dp #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we1_i,
    input  logic          re1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] din1_i,
    output logic [DW-1:0] dout1_o,
    input  logic [AW-1:0] addr2_i,
    output logic [DW-1:0] dout2_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] dout1_q;
    logic [DW-1:0] dout2_q;

    always_ff @(posedge clk_i) begin
        if (we1_i) begin
            mem_q[addr1_i] <= din1_i;
        end
        if (re1_i) begin
            dout1_q <= mem_q[addr1_i];
        end
        dout2_q <= mem_q[addr2_i];
    end

    assign dout1_o = dout1_q;
    assign dout2_o = dout2_q;

endmodule

// File: rtl/vram_banked.sv
// Banked video RAM: handshaked CPU port A, read-only scanout port B, and a constant-fill engine.
//   state   | meaning
//   ST_IDLE | port A may be accepted; a fill request is latched here
//   ST_FILL | one fill word written per clock; port A is stalled
//   ST_DONE | one-cycle completion pulse on fill_done
module vram_banked
    import vram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BANK_AW   = 16,
    parameter int NUM_BANKS = 5,
    parameter int ADDR_W    = 19
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_err,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    fill_state_e       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] val_q;
    logic              busy_q;
    logic              done_q;

    logic              filling;
    logic              a_acc;
    logic              a_rd;
    logic [ADDR_W-1:0] p1_addr;
    logic              p1_wr;
    logic [DATA_W-1:0] p1_din;
    logic [31:0]       p1_bank_w;
    logic              p1_mapped;
    logic [SEL_W-1:0]  p1_sel;
    logic [BANK_AW-1:0] p1_off;

    logic [31:0]       b_bank_w;
    logic              b_mapped;
    logic [SEL_W-1:0]  b_sel;
    logic [BANK_AW-1:0] b_off;

    logic [SEL_W-1:0]  a_sel_q;
    logic              a_map_q;
    logic              a_err_q;
    logic [SEL_W-1:0]  b_sel_q;
    logic              b_map_q;

    logic [DATA_W-1:0] q1 [NUM_BANKS];
    logic [DATA_W-1:0] q2 [NUM_BANKS];

    assign filling = (state_q == ST_FILL);
    assign a_ready = (state_q == ST_IDLE) && !fill_start;
    assign a_acc   = a_en && a_ready;
    assign a_rd    = a_acc && !a_we;

    // Port 1 of every bank is owned by the fill engine while it runs; port A is stalled then anyway.
    assign p1_addr = filling ? ptr_q : a_addr;
    assign p1_wr   = filling ? 1'b1  : (a_acc && a_we);
    assign p1_din  = filling ? val_q : a_din;

    assign p1_bank_w = addr_bank(32'(p1_addr), BANK_AW);
    assign p1_mapped = (p1_bank_w < 32'(NUM_BANKS));
    assign p1_sel    = SEL_W'(p1_bank_w);
    assign p1_off    = BANK_AW'(addr_offset(32'(p1_addr), BANK_AW));

    assign b_bank_w = addr_bank(32'(b_addr), BANK_AW);
    assign b_mapped = (b_bank_w < 32'(NUM_BANKS));
    assign b_sel    = SEL_W'(b_bank_w);
    assign b_off    = BANK_AW'(addr_offset(32'(b_addr), BANK_AW));

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        vram_bank_dp #(
            .AW (BANK_AW),
            .DW (DATA_W)
        ) u_bank (
            .clk_i   (clka),
            .we1_i   (p1_wr && p1_mapped && (p1_sel == SEL_W'(g))),
            .re1_i   (a_rd),
            .addr1_i (p1_off),
            .din1_i  (p1_din),
            .dout1_o (q1[g]),
            .addr2_i (b_off),
            .dout2_o (q2[g])
        );
    end

    // Bank selects are registered next to the RAM read so the output mux never sees the live address.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            a_sel_q <= '0;
            a_map_q <= 1'b0;
            a_err_q <= 1'b0;
            b_sel_q <= '0;
            b_map_q <= 1'b0;
        end else begin
            if (a_acc) begin
                a_err_q <= !p1_mapped;
                if (!a_we) begin
                    a_sel_q <= p1_sel;
                    a_map_q <= p1_mapped;
                end
            end
            b_sel_q <= b_sel;
            b_map_q <= b_mapped;
        end
    end

    always_comb begin
        a_dout = '0;
        b_dout = '0;
        if (a_map_q) begin
            a_dout = q1[a_sel_q];
        end
        if (b_map_q) begin
            b_dout = q2[b_sel_q];
        end
    end

    assign a_err = a_err_q;

    // Remaining count is a down-counter; the last write happens when it holds 1.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        ptr_q  <= fill_base;
                        cnt_q  <= fill_len;
                        val_q  <= fill_value;
                        busy_q <= 1'b1;
                        if (fill_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    ptr_q <= ptr_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fill_busy = busy_q;
    assign fill_done = done_q;

endmodule

// File: tb/tb_vram_banked.sv
// Self-checking bench for vram_banked: port A reads are scoreboarded against a sparse memory model.
// Scanout and fill timing are checked cycle by cycle.
module tb_vram_banked;

    localparam int DATA_W    = 8;
    localparam int BANK_AW   = 16;
    localparam int NUM_BANKS = 5;
    localparam int ADDR_W    = 19;

    logic              clka;
    logic              rst;
    logic              a_en;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic              a_ready;
    logic [DATA_W-1:0] a_dout;
    logic              a_err;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_dout;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_len;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] model [int];
    logic [DATA_W:0]   a_q [$];
    logic [DATA_W-1:0] b_q [$];

    vram_banked #(
        .DATA_W    (DATA_W),
        .BANK_AW   (BANK_AW),
        .NUM_BANKS (NUM_BANKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clka       (clka),
        .rst        (rst),
        .a_en       (a_en),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_din      (a_din),
        .a_ready    (a_ready),
        .a_dout     (a_dout),
        .a_err      (a_err),
        .b_addr     (b_addr),
        .b_dout     (b_dout),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
        return int'(addr[ADDR_W-1:BANK_AW]) < NUM_BANKS;
    endfunction

    // Called just after a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic a_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
        int guard;
        guard  = 0;
        a_en   = 1'b1;
        a_we   = we;
        a_addr = addr;
        a_din  = din;
        #1;
        while (!a_ready && guard < 50) begin
            @(negedge clka);
            #1;
            guard++;
        end
        if (guard >= 50) chk("a_accept_timeout", 32'(guard), 0);
        @(negedge clka);
        a_en = 1'b0;
        a_we = 1'b0;
    endtask

    task automatic a_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
        a_access(1'b1, addr, din);
        if (is_mapped(addr)) model[int'(addr)] = din;
        chk("wr_err", 32'(a_err), 32'(!is_mapped(addr)));
    endtask

    task automatic a_read(input logic [ADDR_W-1:0] addr, input string tag);
        logic [DATA_W:0] e;
        if (is_mapped(addr)) a_q.push_back({1'b0, model[int'(addr)]});
        else                 a_q.push_back({1'b1, {DATA_W{1'b0}}});
        a_access(1'b0, addr, '0);
        e = a_q.pop_front();
        chk({tag, "_dout"}, 32'(a_dout), 32'(e[DATA_W-1:0]));
        chk({tag, "_err"},  32'(a_err),  32'(e[DATA_W]));
    endtask

    // Called just after a falling edge (cycle 0); checks done pulse and a_ready timing.
    task automatic do_fill(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                           input logic [DATA_W-1:0] val, input string tag);
        int done_cyc;
        int done_cnt;
        int rdy_cyc;
        logic busy1;
        done_cyc   = -1;
        done_cnt   = 0;
        rdy_cyc    = -1;
        busy1      = 1'b0;
        fill_start = 1'b1;
        fill_base  = base;
        fill_len   = len;
        fill_value = val;
        #1;
        chk({tag, "_ready_c0"}, 32'(a_ready), 0);
        @(negedge clka);
        fill_start = 1'b0;
        a_en       = 1'b0;
        a_we       = 1'b0;
        for (int c = 1; c <= int'(len) + 8; c++) begin
            if (c == 1) busy1 = fill_busy;
            if (fill_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (a_ready) begin
                rdy_cyc = c;
                break;
            end
            @(negedge clka);
        end
        chk({tag, "_busy_c1"},   32'(busy1), 1);
        chk({tag, "_done_cyc"},  32'(done_cyc), 32'(int'(len) + 1));
        chk({tag, "_done_cnt"},  32'(done_cnt), 1);
        chk({tag, "_ready_cyc"}, 32'(rdy_cyc), 32'(int'(len) + 2));
        for (int k = 0; k < int'(len); k++) begin
            logic [ADDR_W-1:0] p;
            p = base + ADDR_W'(k);
            if (is_mapped(p)) model[int'(p)] = val;
        end
    endtask

    initial begin
        rst        = 1'b1;
        a_en       = 1'b0;
        a_we       = 1'b0;
        a_addr     = '0;
        a_din      = '0;
        b_addr     = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_value = '0;

        repeat (3) @(negedge clka);
        chk("rst_a_dout", 32'(a_dout), 0);
        chk("rst_a_err",  32'(a_err), 0);
        chk("rst_b_dout", 32'(b_dout), 0);
        chk("rst_busy",   32'(fill_busy), 0);
        chk("rst_done",   32'(fill_done), 0);
        chk("rst_ready",  32'(a_ready), 1);
        rst = 1'b0;
        @(negedge clka);

        // Write then read, including bank 4.
        a_write(19'h00010, 8'hA5);
        a_write(19'h40010, 8'h3C);
        a_read(19'h00010, "rd_b0");
        a_read(19'h40010, "rd_b4");

        // Unmapped accesses must not alias onto bank 0.
        a_write(19'h00000, 8'h12);
        a_write(19'h50000, 8'h77);
        a_read(19'h50000, "rd_unmapped");
        a_read(19'h00000, "rd_alias");
        a_read(19'h7FFFF, "rd_unmapped_top");
        a_read(19'h00010, "rd_clear_err");

        // Fill across the bank 0/1 boundary, with guard words on either side.
        a_write(19'h0FFFD, 8'h01);
        a_write(19'h10002, 8'h55);
        do_fill(19'h0FFFE, 19'd4, 8'h11, "fill_x");
        for (int k = 0; k < 6; k++) begin
            logic [ADDR_W-1:0] p;
            p = 19'h0FFFD + ADDR_W'(k);
            a_read(p, "fill_x_rd");
        end

        // Fill request collides with a port A write: the write is dropped.
        a_write(19'h00300, 8'h44);
        a_en   = 1'b1;
        a_we   = 1'b1;
        a_addr = 19'h00300;
        a_din  = 8'h99;
        do_fill(19'h00100, 19'd2, 8'h22, "fill_sim");
        a_read(19'h00300, "sim_a_dropped");
        a_read(19'h00101, "sim_fill_word");

        // Zero-length fill writes nothing.
        a_write(19'h00200, 8'h66);
        do_fill(19'h00200, 19'd0, 8'h33, "fill_zero");
        a_read(19'h00200, "zero_untouched");

        // Scanout read-first while port A writes the same word.
        a_write(19'h00020, 8'h5A);
        b_addr = 19'h00020;
        @(negedge clka);
        b_q.push_back(8'h5A);
        b_q.push_back(8'hEE);
        a_en   = 1'b1;
        a_we   = 1'b1;
        a_addr = 19'h00020;
        a_din  = 8'hEE;
        #1;
        chk("scan_a_ready", 32'(a_ready), 1);
        @(negedge clka);
        a_en = 1'b0;
        a_we = 1'b0;
        model[32'h20] = 8'hEE;
        chk("scan_old", 32'(b_dout), 32'(b_q.pop_front()));
        @(negedge clka);
        chk("scan_new", 32'(b_dout), 32'(b_q.pop_front()));
        b_addr = 19'h40010;
        @(negedge clka);
        @(negedge clka);
        chk("scan_b4", 32'(b_dout), 32'h3C);
        b_addr = 19'h50000;
        @(negedge clka);
        @(negedge clka);
        chk("scan_unmapped", 32'(b_dout), 0);
        b_addr = 19'h00020;

        // Reset in the middle of a long fill; words already written survive.
        a_write(19'h02003, 8'h01);
        a_read(19'h00010, "pre_rst_rd");
        fill_start = 1'b1;
        fill_base  = 19'h02000;
        fill_len   = 19'd20;
        fill_value = 8'h7E;
        @(negedge clka);
        fill_start = 1'b0;
        repeat (3) @(negedge clka);
        chk("mid_busy", 32'(fill_busy), 1);
        rst = 1'b1;
        #1;
        chk("mrst_busy",  32'(fill_busy), 0);
        chk("mrst_done",  32'(fill_done), 0);
        chk("mrst_a_dout", 32'(a_dout), 0);
        chk("mrst_a_err", 32'(a_err), 0);
        chk("mrst_b_dout", 32'(b_dout), 0);
        chk("mrst_ready", 32'(a_ready), 1);
        @(negedge clka);
        rst = 1'b0;
        @(negedge clka);
        model[32'h2000] = 8'h7E;
        model[32'h2001] = 8'h7E;
        model[32'h2002] = 8'h7E;
        a_read(19'h02000, "mrst_w0");
        a_read(19'h02002, "mrst_w2");
        a_read(19'h02003, "mrst_w3");
        @(negedge clka);
        chk("post_rst_busy", 32'(fill_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
